mem_access_unit: RTL and testbench

//  MEM-stage responder for the 2-bit MemRead/MemWrite size codes from the main decoder
//  (00 none, 01 word, 10 byte, 11 half).
//  - Serialises word, half and byte loads/stores onto an 8-bit req/ack data bus, big-endian.
//  - Sign-extends loads (lb/lh).
//  - Stalls the pipeline until the access completes.
//  - Flags misaligned, illegal and timed-out accesses.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage access unit: size codes, FSM states, beat-count helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_pkg;

    // Size codes as emitted by the main decoder on mem_read / mem_write.
    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_WORD = 2'b01,
        MEM_BYTE = 2'b10,
        MEM_HALF = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } mem_state_e;

    // Index of the final byte beat for a given access size.
    function automatic logic [1:0] last_idx(input mem_size_e size);
        case (size)
            MEM_WORD: last_idx = 2'd3;
            MEM_HALF: last_idx = 2'd1;
            default:  last_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Byte-wide req/ack memory bus between the access unit (master) and memory (slave).
// Latency: n/a (wires only).
// Backpressure: slave holds off completion by withholding bus_ack; master keeps the beat stable.
interface mem_access_unit_if #(
    parameter int AW = 32
);
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wdata;
    logic [7:0]    bus_rdata;
    logic          bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );
endinterface

// File: rtl/mem_load_align.sv
// Turns the big-endian assembled load bytes into the architectural result (sign-extended lb/lh).
// Latency: combinational.
// Backpressure: none; result is only meaningful while the parent reports done.
module mem_load_align
    import mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic        is_load,
    input  logic [31:0] asm_dat,
    output logic [31:0] rdata
);

    // Select width and extend; stores report zero.
    always_comb begin
        rdata = 32'd0;
        if (is_load) begin
            case (size)
                MEM_WORD: rdata = asm_dat;
                MEM_HALF: rdata = {{16{asm_dat[15]}}, asm_dat[15:0]};
                MEM_BYTE: rdata = {{24{asm_dat[7]}}, asm_dat[7:0]};
                default:  rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage responder: serialises word/half/byte loads and stores onto a byte req/ack bus.
// Latency: 2 + beats cycles request->done on a zero-wait bus (word 6, half 4, byte 3); +1 per wait.
// Backpressure: stalls the pipeline while a beat is outstanding; a slow bus_ack stretches each beat.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int          AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mem_read,
    input  logic [1:0]        mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done,
    output logic              fault,
    mem_access_unit_if.master bus
);

    localparam logic        TMO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    mem_state_e    state_q;
    mem_size_e     size_q;
    logic          store_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    idx_q;
    logic [1:0]    last_q;
    logic [15:0]   tmo_q;
    logic [31:0]   asm_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic          done_q;
    logic          fault_q;

    logic          req_present;
    mem_size_e     size_sel;
    logic          illegal;
    logic          misaligned;
    logic [1:0]    byte_sel;
    logic [31:0]   align_rdata;

    // Decode the incoming request; a load code takes precedence for sizing.
    always_comb begin
        req_present = (mem_read != 2'b00) || (mem_write != 2'b00);
        size_sel    = (mem_read != 2'b00) ? mem_size_e'(mem_read) : mem_size_e'(mem_write);
        illegal     = (mem_read != 2'b00) && (mem_write != 2'b00);
        misaligned  = ((size_sel == MEM_HALF) && addr[0]) ||
                      ((size_sel == MEM_WORD) && (addr[1:0] != 2'b00));
        // Big-endian: beat 0 carries the most significant byte of the access.
        byte_sel    = last_q - idx_q;
    end

    // FSM, beat index, timeout counter and load assembly, with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            size_q    <= MEM_NONE;
            store_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            idx_q     <= 2'd0;
            last_q    <= 2'd0;
            tmo_q     <= 16'd0;
            asm_q     <= 32'd0;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_present) begin
                        size_q  <= size_sel;
                        store_q <= (mem_write != 2'b00);
                        addr_q  <= AW'(addr);
                        wdata_q <= wdata;
                        idx_q   <= 2'd0;
                        last_q  <= last_idx(size_sel);
                        tmo_q   <= 16'd0;
                        asm_q   <= 32'd0;
                        if (illegal || misaligned) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q   <= ST_XFER;
                            bus_req_q <= 1'b1;
                            bus_we_q  <= (mem_write != 2'b00);
                        end
                    end
                end
                ST_XFER: begin
                    if (bus.bus_ack) begin
                        tmo_q <= 16'd0;
                        if (!store_q) begin
                            asm_q <= {asm_q[23:0], bus.bus_rdata};
                        end
                        if (idx_q == last_q) begin
                            state_q   <= ST_DONE;
                            bus_req_q <= 1'b0;
                            bus_we_q  <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                        // Abandon the beat: the bus sees the request withdrawn.
                        state_q   <= ST_FAULT;
                        bus_req_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        fault_q   <= 1'b1;
                    end else if (TMO_EN) begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    mem_load_align u_align (
        .size    (size_q),
        .is_load (!store_q),
        .asm_dat (asm_q),
        .rdata   (align_rdata)
    );

    // Pipeline-side and bus-side outputs; beat address/data only move after an ack.
    always_comb begin
        stall         = ((state_q == ST_IDLE) && req_present) || (state_q == ST_XFER);
        done          = done_q;
        fault         = fault_q;
        rdata         = done_q ? align_rdata : 32'd0;
        bus.bus_req   = bus_req_q;
        bus.bus_we    = bus_we_q;
        bus.bus_addr  = bus_req_q ? (addr_q + AW'(idx_q)) : '0;
        bus.bus_wdata = bus_we_q ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'd0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus hand sequences for wait states and reset.
// Latency: n/a.
// Backpressure: the memory model inserts a programmable number of wait cycles per beat.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;

    mem_access_unit_if #(.AW(32)) bif ();

    mem_access_unit #(.AW(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .done      (done),
        .fault     (fault),
        .bus       (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory model state.
    logic [7:0]  mem [0:1023];
    int          wait_n   = 0;
    int          wcnt     = 0;
    int          unstable = 0;
    logic        ack_drv  = 1'b0;
    logic [7:0]  rdat_drv = 8'd0;
    logic [31:0] beat_addr;
    logic [7:0]  beat_wdat;
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];

    assign bif.bus_ack   = ack_drv;
    assign bif.bus_rdata = rdat_drv;

    // Memory responder: acks after wait_n idle cycles per beat, logs writes, watches beat stability.
    always @(negedge clk) begin
        if (bif.bus_req) begin
            if (wcnt == 0) begin
                beat_addr = bif.bus_addr;
                beat_wdat = bif.bus_wdata;
            end else if (bif.bus_addr !== beat_addr || bif.bus_wdata !== beat_wdat) begin
                unstable++;
            end
            if (wcnt >= wait_n) begin
                ack_drv  = 1'b1;
                rdat_drv = mem[bif.bus_addr[9:0]];
                if (bif.bus_we) begin
                    wlog_a.push_back(bif.bus_addr);
                    wlog_d.push_back(bif.bus_wdata);
                end
                wcnt = 0;
            end else begin
                ack_drv = 1'b0;
                wcnt++;
            end
        end else begin
            ack_drv = 1'b0;
            wcnt    = 0;
        end
    end

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] pre;
        int          wait_n;
        logic        exp_fault;
        logic [31:0] exp_rdata;
        int          exp_cyc;
        logic        exp_req;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one access from an idle unit and follow it to its done/fault pulse.
    task automatic run_access(input vec_t v, input string nm);
        int          cyc;
        logic        got;
        logic        req_seen;
        logic        out_fault;
        logic [31:0] out_rdata;
        logic        req_end;
        for (int i = 0; i < 4; i++) begin
            mem[v.addr[9:0] + 10'(i)] = v.pre[31 - 8*i -: 8];
        end
        wait_n = v.wait_n;
        @(negedge clk);
        mem_read  = v.rd;
        mem_write = v.wr;
        addr      = v.addr;
        wdata     = v.wdat;
        #1;
        check({nm, ".stall_req"}, 32'(stall), 32'd1);
        cyc = 1; got = 1'b0; req_seen = 1'b0;
        out_fault = 1'b0; out_rdata = 32'd0; req_end = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                mem_read  = 2'b00;
                mem_write = 2'b00;
                addr      = 32'd0;
                wdata     = 32'd0;
            end
            if (bif.bus_req) req_seen = 1'b1;
            if (done || fault) begin
                got       = 1'b1;
                out_fault = fault;
                out_rdata = rdata;
                req_end   = bif.bus_req;
            end
        end
        check({nm, ".ended"},  32'(got),       32'd1);
        check({nm, ".fault"},  32'(out_fault), 32'(v.exp_fault));
        check({nm, ".cycles"}, 32'(cyc),       32'(v.exp_cyc));
        check({nm, ".rdata"},  out_rdata,      v.exp_rdata);
        check({nm, ".req_seen"}, 32'(req_seen), 32'(v.exp_req));
        check({nm, ".req_end"},  32'(req_end),  32'd0);
        @(negedge clk);
        check({nm, ".pulse"}, {29'd0, done, fault, stall}, 32'd0);
    endtask

    int          base;
    logic        seen;
    logic [31:0] la0, la1;
    logic [7:0]  ld0, ld1;
    vec_t        hv;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst_n = 1'b0; mem_read = 2'b00; mem_write = 2'b00; addr = 32'd0; wdata = 32'd0;

        //             rd     wr     addr        wdata         preload       wt  flt   rdata         cyc req
        vecs[0]  = '{2'b01, 2'b00, 32'h100, 32'h0,        32'hDEADBEEF, 0,   1'b0, 32'hDEADBEEF, 6,  1'b1};
        vecs[1]  = '{2'b10, 2'b00, 32'h103, 32'h0,        32'h80000000, 0,   1'b0, 32'hFFFFFF80, 3,  1'b1};
        vecs[2]  = '{2'b11, 2'b00, 32'h010, 32'h0,        32'h7FFF0000, 0,   1'b0, 32'h00007FFF, 4,  1'b1};
        vecs[3]  = '{2'b11, 2'b00, 32'h020, 32'h0,        32'h80010000, 0,   1'b0, 32'hFFFF8001, 4,  1'b1};
        vecs[4]  = '{2'b10, 2'b00, 32'h031, 32'h0,        32'h7F000000, 0,   1'b0, 32'h0000007F, 3,  1'b1};
        vecs[5]  = '{2'b01, 2'b00, 32'h040, 32'h0,        32'h01020304, 1,   1'b0, 32'h01020304, 10, 1'b1};
        vecs[6]  = '{2'b00, 2'b01, 32'h080, 32'h11223344, 32'h0,        0,   1'b0, 32'h0,        6,  1'b1};
        vecs[7]  = '{2'b00, 2'b10, 32'h085, 32'hAABBCCDD, 32'h0,        0,   1'b0, 32'h0,        3,  1'b1};
        vecs[8]  = '{2'b11, 2'b00, 32'h101, 32'h0,        32'h0,        0,   1'b1, 32'h0,        2,  1'b0};
        vecs[9]  = '{2'b01, 2'b00, 32'h102, 32'h0,        32'h0,        0,   1'b1, 32'h0,        2,  1'b0};
        vecs[10] = '{2'b01, 2'b01, 32'h100, 32'h0,        32'h0,        0,   1'b1, 32'h0,        2,  1'b0};
        vecs[11] = '{2'b00, 2'b11, 32'h103, 32'h5555,     32'h0,        0,   1'b1, 32'h0,        2,  1'b0};
        vecs[12] = '{2'b01, 2'b00, 32'h104, 32'h0,        32'h0,        255, 1'b1, 32'h0,        6,  1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset.bus_req", 32'(bif.bus_req), 32'd0);
        check("reset.bus_addr", bif.bus_addr, 32'd0);
        check("reset.outs", {28'd0, done, fault, stall, bif.bus_we}, 32'd0);
        check("reset.rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_access(vecs[i], $sformatf("vec%0d", i));
        end

        // Half store with two wait cycles per beat: byte order, addresses, stability.
        base = wlog_a.size();
        unstable = 0;
        hv = '{2'b00, 2'b11, 32'h202, 32'h1234ABCD, 32'h0, 2, 1'b0, 32'h0, 8, 1'b1};
        run_access(hv, "sh_wait");
        check("sh_wait.nwrites", 32'(wlog_a.size() - base), 32'd2);
        la0 = (wlog_a.size() > base)     ? wlog_a[base]     : 32'd0;
        ld0 = (wlog_a.size() > base)     ? wlog_d[base]     : 8'd0;
        la1 = (wlog_a.size() > base + 1) ? wlog_a[base + 1] : 32'd0;
        ld1 = (wlog_a.size() > base + 1) ? wlog_d[base + 1] : 8'd0;
        check("sh_wait.addr0", la0, 32'h202);
        check("sh_wait.data0", 32'(ld0), 32'hAB);
        check("sh_wait.addr1", la1, 32'h203);
        check("sh_wait.data1", 32'(ld1), 32'hCD);
        check("sh_wait.stable", 32'(unstable), 32'd0);

        // Reset asserted while the third beat of a word store is on the bus.
        base = wlog_a.size();
        wait_n = 0;
        @(negedge clk);
        mem_write = 2'b01; addr = 32'h300; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_write = 2'b00; addr = 32'd0; wdata = 32'd0;
        @(posedge clk);
        @(posedge clk); #2;
        check("rst_mid.addr", bif.bus_addr, 32'h302);
        check("rst_mid.wdata", 32'(bif.bus_wdata), 32'hF0);
        check("rst_mid.req_before", 32'(bif.bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.req_drop", 32'(bif.bus_req), 32'd0);
        check("rst_mid.outs", {29'd0, done, fault, stall}, 32'd0);
        check("rst_mid.nwrites", 32'(wlog_a.size() - base), 32'd2);
        la0 = (wlog_a.size() > base)     ? wlog_a[base]     : 32'd0;
        ld0 = (wlog_a.size() > base)     ? wlog_d[base]     : 8'd0;
        ld1 = (wlog_a.size() > base + 1) ? wlog_d[base + 1] : 8'd0;
        check("rst_mid.addr0", la0, 32'h300);
        check("rst_mid.data0", 32'(ld0), 32'hCA);
        check("rst_mid.data1", 32'(ld1), 32'hFE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || fault || bif.bus_req) seen = 1'b1;
        end
        check("rst_mid.quiet", 32'(seen), 32'd0);
        hv = '{2'b10, 2'b00, 32'h305, 32'h0, 32'h9C000000, 0, 1'b0, 32'hFFFFFF9C, 3, 1'b1};
        run_access(hv, "lb_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
